// File: rtl/mining_pkg.sv
// Shared definitions for the message-RAM sequencer slice: FSM state encoding
// (also driven onto the RAM state input) and message/block geometry.
// Ports: none (package).
package mining_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int MSG_BYTES       = 512;
  localparam int BLOCK_BYTES     = 64;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORDS_PER_BLOCK = BLOCK_BYTES / BYTES_PER_WORD;
  localparam int MSG_ADDR_WIDTH  = $clog2(MSG_BYTES);

endpackage

// File: rtl/msg_mem_sequencer_if.sv
// Bundle for the sequencer: upstream byte stream, message RAM port and the
// word stream toward the message-schedule stage.
// Modports: master = sequencer side, slave = environment (source/RAM/sink).
interface msg_mem_sequencer_if
  import mining_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = MSG_ADDR_WIDTH
);

  logic                                 in_valid;
  logic [DATA_WIDTH-1:0]                in_data;
  logic                                 in_ready;
  logic                                 mem_we;
  logic [ADDR_WIDTH-1:0]                mem_waddr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic                                 mem_re;
  logic [ADDR_WIDTH-1:0]                mem_raddr;
  logic [DATA_WIDTH-1:0]                mem_rdata;
  state_t                               mem_state;
  logic                                 word_valid;
  logic                                 word_ready;
  logic [BYTES_PER_WORD*DATA_WIDTH-1:0] word_data;
  logic                                 word_blk_last;
  logic                                 word_last;

  modport master (
    input  in_valid, in_data, mem_rdata, word_ready,
    output in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           mem_state, word_valid, word_data, word_blk_last, word_last
  );

  modport slave (
    output in_valid, in_data, mem_rdata, word_ready,
    input  in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           mem_state, word_valid, word_data, word_blk_last, word_last
  );

endinterface

// File: rtl/byte_packer.sv
// Packs registered RAM read bytes big-endian into a word and holds it on a
// valid/ready output; o_room tells the issue logic whether another read fits.
// Ports: i_issue (read launched), i_rdata, i_rdy in; o_room, o_vld, o_dat out.
module byte_packer
  import mining_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_issue,
  input  logic [DATA_WIDTH-1:0]                i_rdata,
  input  logic                                 i_rdy,
  output logic                                 o_room,
  output logic                                 o_vld,
  output logic [BYTES_PER_WORD*DATA_WIDTH-1:0] o_dat
);

  localparam int WORD_BITS = BYTES_PER_WORD * DATA_WIDTH;
  localparam logic [2:0] FULL = 3'(BYTES_PER_WORD);

  logic [2:0]           r_held;
  logic                 r_pend;
  logic [WORD_BITS-1:0] r_shift;
  logic [2:0]           w_fill;

  // A read in flight already owns a slot, so count it against capacity.
  assign w_fill = r_held + {2'b00, r_pend};
  assign o_room = (w_fill < FULL);
  assign o_vld  = (r_held == FULL);
  assign o_dat  = r_shift;

  // Capture and accept never coincide: a full word leaves no room to issue,
  // so no byte can be pending while the word is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held  <= '0;
      r_pend  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_pend <= i_issue;
      if (r_pend) begin
        r_shift <= {r_shift[WORD_BITS-DATA_WIDTH-1:0], i_rdata};
        r_held  <= r_held + 3'd1;
      end else if (o_vld && i_rdy) begin
        r_held <= '0;
      end
    end
  end

endmodule

// File: rtl/msg_mem_sequencer.sv
// Message RAM sequencer: fills the message RAM from a byte stream, then drains
// it as big-endian 32-bit words tagged with 64-byte block boundary flags.
// Ports: clk/reset/start in, busy/done out; byte stream, RAM, word stream on bus.
module msg_mem_sequencer
  import mining_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = MSG_BYTES,
  parameter int ADDR_WIDTH = MSG_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  msg_mem_sequencer_if.master bus
);

  localparam int NUM_WORDS  = DATA_DEPTH / BYTES_PER_WORD;
  localparam int WIDX_WIDTH = $clog2(NUM_WORDS);
  localparam int BLK_BITS   = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [WIDX_WIDTH-1:0] LAST_WIDX = WIDX_WIDTH'(NUM_WORDS - 1);

  state_t                               r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]                r_waddr, r_raddr;
  logic                                 r_rd_all;  // final address already issued
  logic [WIDX_WIDTH-1:0]                r_widx;
  logic                                 w_we, w_issue, w_room, w_acc;
  logic                                 w_last_word, w_load_done;
  logic                                 w_word_vld;
  logic [BYTES_PER_WORD*DATA_WIDTH-1:0] w_word_dat;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.in_ready = 1'b0;
    w_we         = 1'b0;
    w_issue      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        w_we         = bus.in_valid;
        if (w_we && (r_waddr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_issue = w_room && !r_rd_all;
        if (w_acc && w_last_word) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_load_done = w_we && (r_waddr == LAST_ADDR);
  assign w_acc       = w_word_vld && bus.word_ready;
  assign w_last_word = (r_widx == LAST_WIDX);

  assign bus.mem_we        = w_we;
  assign bus.mem_waddr     = r_waddr;
  assign bus.mem_wdata     = bus.in_ready ? bus.in_data : '0;
  assign bus.mem_re        = w_issue;
  assign bus.mem_raddr     = r_raddr;
  assign bus.mem_state     = r_state;
  assign bus.word_valid    = w_word_vld;
  assign bus.word_data     = w_word_dat;
  assign bus.word_blk_last = w_word_vld && (r_widx[BLK_BITS-1:0] == '1);
  assign bus.word_last     = w_word_vld && w_last_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_rd_all <= 1'b0;
      r_widx   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start)
        r_waddr <= '0;
      else if (w_we)
        r_waddr <= w_load_done ? '0 : r_waddr + ADDR_WIDTH'(1);

      if (w_load_done) begin
        r_raddr  <= '0;
        r_rd_all <= 1'b0;
        r_widx   <= '0;
      end else begin
        // The read counter parks on the last address; r_rd_all stops issue.
        if (w_issue) begin
          if (r_raddr == LAST_ADDR) r_rd_all <= 1'b1;
          else                      r_raddr  <= r_raddr + ADDR_WIDTH'(1);
        end
        if (w_acc) r_widx <= w_last_word ? '0 : r_widx + WIDX_WIDTH'(1);
      end
    end
  end

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_issue (w_issue),
    .i_rdata (bus.mem_rdata),
    .i_rdy   (bus.word_ready),
    .o_room  (w_room),
    .o_vld   (w_word_vld),
    .o_dat   (w_word_dat)
  );

endmodule

// File: tb/tb_msg_mem_sequencer.sv
// Bench for msg_mem_sequencer: byte source, message RAM model, word sink with
// a scoreboard of expected words built from the bytes offered upstream.
// Ports: none (top-level bench).
module tb_msg_mem_sequencer;
  import mining_pkg::*;

  typedef struct packed {
    logic [31:0] dat;
    logic        blk;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, busy, done;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  exp_t exp_q[$];
  int   words_rx = 0;
  int   done_cnt = 0;
  int   last_acc_cyc = 0;
  int   prev_acc_cyc = 0;
  bit   have_prev = 1'b0;
  bit   stalled = 1'b0;
  exp_t held;
  int   exp_waddr = 0;
  int   exp_raddr = 0;
  bit   space_chk = 1'b0;
  bit   rdy_rand = 1'b0;

  logic [7:0] ram [512];

  msg_mem_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus ();

  msg_mem_sequencer #(.DATA_WIDTH(8), .DATA_DEPTH(512), .ADDR_WIDTH(9)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Message RAM: registered read, data held until the next read.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_raddr];
  end

  // Downstream sink readiness.
  initial begin
    bus.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.word_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: address streams, stall stability, scoreboard, done timing.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (!busy) begin
        exp_waddr = 0;
        exp_raddr = 0;
        have_prev = 1'b0;
      end
      if (bus.mem_we) begin
        chk("waddr", 64'(bus.mem_waddr), 64'(exp_waddr));
        chk("wdata", 64'(bus.mem_wdata), 64'(bus.in_data));
        exp_waddr++;
      end
      if (!bus.in_valid) chk("we_without_valid", 64'(bus.mem_we), 64'(0));
      if (bus.mem_re) begin
        chk("raddr", 64'(bus.mem_raddr), 64'(exp_raddr));
        chk("raddr_in_range", 64'(exp_raddr < 512), 64'(1));
        exp_raddr++;
      end
      if (stalled) begin
        chk("stall_valid", 64'(bus.word_valid), 64'(1));
        chk("stall_data", 64'(bus.word_data), 64'(held.dat));
        chk("stall_blk_last", 64'(bus.word_blk_last), 64'(held.blk));
        chk("stall_last", 64'(bus.word_last), 64'(held.last));
      end
      stalled = 1'b0;
      if (bus.word_valid && bus.word_ready) begin
        chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", 64'(bus.word_data), 64'(e.dat));
          chk("word_blk_last", 64'(bus.word_blk_last), 64'(e.blk));
          chk("word_last", 64'(bus.word_last), 64'(e.last));
        end
        if (space_chk && have_prev) chk("word_spacing", 64'(cyc - prev_acc_cyc), 64'(6));
        words_rx++;
        prev_acc_cyc = cyc;
        last_acc_cyc = cyc;
        have_prev = 1'b1;
      end else if (bus.word_valid) begin
        stalled   = 1'b1;
        held.dat  = bus.word_data;
        held.blk  = bus.word_blk_last;
        held.last = bus.word_last;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_accept", 64'(cyc - last_acc_cyc), 64'(1));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'(0));
    chk({tag, "_mem_we"},    64'(bus.mem_we), 64'(0));
    chk({tag, "_mem_re"},    64'(bus.mem_re), 64'(0));
    chk({tag, "_mem_waddr"}, 64'(bus.mem_waddr), 64'(0));
    chk({tag, "_mem_raddr"}, 64'(bus.mem_raddr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, "_word_vld"},  64'(bus.word_valid), 64'(0));
    chk({tag, "_word_data"}, 64'(bus.word_data), 64'(0));
    chk({tag, "_blk_last"},  64'(bus.word_blk_last), 64'(0));
    chk({tag, "_word_last"}, 64'(bus.word_last), 64'(0));
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_done"},      64'(done), 64'(0));
    chk({tag, "_mem_state"}, 64'(bus.mem_state), 64'(0));
  endtask

  // One job: start, feed 512 bytes, drain (or abort after abort_at words).
  task automatic run_job(input bit gap, input bit addr_data, input bit extra_start,
                         input int abort_at);
    int n, k, first_wr, last_wr, w0, d0;
    logic [31:0] acc;
    logic [7:0]  b;
    exp_t        e;
    w0 = words_rx;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; k = 0; acc = '0; first_wr = 0; last_wr = 0;
    while (n < 512 && k < 4000) begin
      b = addr_data ? n[7:0] : 8'($urandom);
      bus.in_valid = gap ? (k % 3 == 0) : 1'b1;
      bus.in_data  = b;
      start = extra_start && (k == 100);
      @(negedge clk);
      if (bus.in_valid) begin
        chk("in_ready_in_load", 64'(bus.in_ready), 64'(1));
        if (n == 0) first_wr = cyc;
        last_wr = cyc;
        acc = {acc[23:0], b};
        if (n % 4 == 3) begin
          e.dat  = acc;
          e.blk  = ((n / 4) % 16 == 15);
          e.last = (n / 4 == 127);
          exp_q.push_back(e);
        end
        n++;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    chk("load_bytes", 64'(n), 64'(512));
    chk("drain_entry_state", 64'(bus.mem_state), 64'(2));
    chk("in_ready_in_drain", 64'(bus.in_ready), 64'(0));
    if (!gap) chk("load_consecutive", 64'(last_wr - first_wr), 64'(511));

    k = 0;
    while ((words_rx - w0) < 128 && k < 20000) begin
      if (abort_at >= 0 && (words_rx - w0) >= abort_at) break;
      start = extra_start && (k == 50);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_point", 64'(words_rx - w0), 64'(abort_at));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("abort");
      @(posedge clk); #1 reset = 1'b0;
      exp_q.delete();
    end else begin
      chk("drain_in_time", 64'(k < 20000), 64'(1));
      repeat (4) @(posedge clk);
      #1;
      chk("word_count", 64'(words_rx - w0), 64'(128));
      chk("done_once", 64'(done_cnt - d0), 64'(1));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      chk("idle_after_job", 64'(bus.mem_state), 64'(0));
      chk("busy_after_job", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Address-pattern bytes, sink always ready: fixed word cadence.
    space_chk = 1'b1;
    rdy_rand  = 1'b0;
    run_job(1'b0, 1'b1, 1'b0, -1);

    // Random bytes, gapped source, random backpressure, stray start pulses.
    space_chk = 1'b0;
    rdy_rand  = 1'b1;
    run_job(1'b1, 1'b0, 1'b1, -1);

    // Abort in the middle of the drain, then a clean rerun.
    run_job(1'b0, 1'b0, 1'b0, 40);
    rdy_rand = 1'b0;
    run_job(1'b0, 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
